// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad scanner.
//   state_e     : scanner FSM states (SCAN, DEB_PRESS, HELD)
//   code_w()    : width of a linear key code for a rows x cols matrix
//   DEF_*       : default parameter values for keypad_scan_fifo
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2
    } state_e;

    localparam int DEF_ROWS            = 4;
    localparam int DEF_COLS            = 4;
    localparam int DEF_SCAN_CYCLES     = 1000;
    localparam int DEF_DEBOUNCE_CYCLES = 10000;
    localparam int DEF_FIFO_DEPTH      = 8;
    localparam int DEF_REPEAT_CYCLES   = 500000;

    function automatic int code_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: first-word-fall-through circular buffer.
//   clk, rst      : clock, synchronous active-low reset
//   push_i        : write push_data_i (ignored when full unless popping)
//   push_data_i   : WIDTH-bit entry to write
//   full_o        : DEPTH entries stored
//   pop_i         : consume the head entry (ignored when empty)
//   valid_o       : buffer non-empty, data_o is the head entry
//   data_o        : head entry; holds its last value while empty
// Pointers are one bit wider than the address so full/empty are unambiguous.
module keypad_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q, rd_inc, level;
    logic [WIDTH-1:0] head_q;
    logic             empty, full, do_push, do_pop, load_mem, load_in;

    assign level   = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = level[AW];           // level never exceeds DEPTH
    assign rd_inc  = rd_q + 1'b1;
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    // Head register: next stored entry on a pop with more data behind it,
    // or the incoming word when the buffer is (or is about to be) empty.
    assign load_mem = do_pop && (level > LEVEL_ONE);
    assign load_in  = do_push && (empty || (do_pop && level == LEVEL_ONE));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_inc;
            if (load_mem) begin
                head_q <= mem[rd_inc[AW-1:0]];
            end else if (load_in) begin
                head_q <= push_data_i;
            end
        end
    end

    assign full_o  = full;
    assign valid_o = !empty;
    assign data_o  = head_q;

endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix keypad scanner with debounce and key-code FIFO.
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   fila       : ROWS row sense lines, active-high, asynchronous
//   columna    : COLS one-hot column drive
//   key_code   : head-of-FIFO code, row*COLS+col
//   key_valid  : FIFO non-empty
//   key_ready  : consumer accepts the head entry
//   overflow   : sticky, a key was dropped on a full FIFO
// Optional feature: define KEYPAD_REPEAT_EN to re-push a held key every
// REPEAT_CYCLES cycles.
module keypad_scan_fifo
    import keypad_pkg::*;
#(
    parameter int ROWS            = DEF_ROWS,
    parameter int COLS            = DEF_COLS,
    parameter int SCAN_CYCLES     = DEF_SCAN_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ROWS-1:0]                      fila,
    output logic [COLS-1:0]                      columna,
    output logic [code_w(ROWS, COLS)-1:0]        key_code,
    output logic                                 key_valid,
    input  logic                                 key_ready,
    output logic                                 overflow
);

    localparam int CODE_W = code_w(ROWS, COLS);
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int DW     = $clog2(SCAN_CYCLES);
    localparam int BW     = $clog2(DEBOUNCE_CYCLES);
    localparam int PW     = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] REP_LAST   = PW'(REPEAT_CYCLES - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ROWS-1:0]   fs_meta_q, fs_q;
    logic [CW-1:0]     col_q, col_d, col_nxt;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [BW-1:0]     deb_q, deb_d;
    logic [PW-1:0]     rep_q, rep_d;
    logic [RW-1:0]     row_q, row_d, low_row;
    logic              ovf_q, ovf_d;
    logic              push, cand_hit, fifo_full, pop;
    logic [CODE_W-1:0] push_code;

    // One-hot column drive from the column index.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign columna[gi] = (col_q == CW'(gi));
        end
    endgenerate

    // Lowest set row wins when several rows are active.
    always_comb begin
        low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (fs_q[i]) low_row = RW'(i);
        end
    end

    // The column is frozen during DEB_PRESS/HELD, so col_q is the candidate column.
    assign cand_hit  = fs_q[row_q];
    assign col_nxt   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    assign push_code = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_q);
    assign pop       = key_valid && key_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        rep_d   = rep_q;
        row_d   = row_q;
        push    = 1'b0;
        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (fs_q == '0) begin
                        col_d = col_nxt;
                    end else begin
                        row_d   = low_row;
                        deb_d   = '0;
                        state_d = DEB_PRESS;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (!cand_hit) begin
                    state_d = SCAN;     // bounce: re-dwell on the same column
                    dwell_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    push    = 1'b1;
                    deb_d   = '0;
                    rep_d   = '0;
                    state_d = HELD;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            HELD: begin
                if (cand_hit) begin
                    deb_d = '0;
                    if (REPEAT_ON) begin
                        if (rep_q == REP_LAST) begin
                            push  = 1'b1;
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end else begin
                    rep_d = '0;         // release restarts the repeat period
                    if (deb_q == DEB_LAST) begin
                        state_d = SCAN;
                        dwell_d = '0;
                        col_d   = col_nxt;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // A push is lost only when full and no pop frees a slot that same cycle.
    assign ovf_d = ovf_q | (push & fifo_full & ~pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SCAN;
            fs_meta_q <= '0;
            fs_q      <= '0;
            col_q     <= '0;
            dwell_q   <= '0;
            deb_q     <= '0;
            rep_q     <= '0;
            row_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fs_meta_q <= fila;
            fs_q      <= fs_meta_q;
            col_q     <= col_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            rep_q     <= rep_d;
            row_q     <= row_d;
            ovf_q     <= ovf_d;
        end
    end

    keypad_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_code),
        .full_o      (fifo_full),
        .pop_i       (pop),
        .valid_o     (key_valid),
        .data_o      (key_code)
    );

    assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo: directed bench for keypad_scan_fifo using a 4x4 key
// matrix model; fila reflects pressed keys in the currently driven column.
module tb_keypad_scan_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] fila;
    logic [3:0] columna;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;

    logic [15:0] keys;          // keys[r*4+c] pressed => code r*4+c
    logic [3:0]  popped [$];
    int          tests_run;
    int          tests_failed;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_HOLD_PUSHES = 4;
`else
    localparam int EXP_HOLD_PUSHES = 1;
`endif

    keypad_scan_fifo #(
        .ROWS            (4),
        .COLS            (4),
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8),
        .FIFO_DEPTH      (4),
        .REPEAT_CYCLES   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fila      (fila),
        .columna   (columna),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        fila = '0;
        for (int r = 0; r < 4; r++) begin
            fila[r] = |(keys[r*4 +: 4] & columna);
        end
    end

    // Pop monitor: one line per accepted key.
    always @(negedge clk) begin
        if (rst && key_valid && key_ready) begin
            popped.push_back(key_code);
            $display("[TB] pop code=%0d at %0t", key_code, $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one tick after columna switches to target (dwell counter at 0).
    task automatic wait_col(input logic [3:0] target);
        int n = 0;
        while (columna == target && n < 64) begin tick(); n++; end
        while (columna != target && n < 64) begin tick(); n++; end
        check_val("wait_col", 32'(columna), 32'(target));
    endtask

    task automatic press_release(input int code);
        keys[code] = 1'b1;
        repeat (40) tick();
        keys[code] = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        int base;
        int lat;
        int n;
        tests_run    = 0;
        tests_failed = 0;
        keys      = '0;
        key_ready = 1'b1;
        rst       = 1'b0;

        // 1: reset state and free-running scan
        repeat (5) tick();
        check_val("rst_columna", 32'(columna), 32'd1);
        check_val("rst_valid", 32'(key_valid), 32'd0);
        check_val("rst_code", 32'(key_code), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        repeat (4) tick(); check_val("scan_col1", 32'(columna), 32'b0010);
        repeat (4) tick(); check_val("scan_col2", 32'(columna), 32'b0100);
        repeat (4) tick(); check_val("scan_col3", 32'(columna), 32'b1000);
        repeat (4) tick(); check_val("scan_wrap", 32'(columna), 32'b0001);
        check_val("scan_valid", 32'(key_valid), 32'd0);
        check_val("scan_overflow", 32'(overflow), 32'd0);

        // 2: single press row 2 col 1 -> code 9, latency bound
        base = popped.size();
        wait_col(4'b0010);
        keys[9] = 1'b1;
        lat = 0;
        while (!key_valid && lat < 40) begin tick(); lat++; end
        check_val("t2_latency_ok", 32'(lat <= 15), 32'd1);
        check_val("t2_code", 32'(key_code), 32'd9);
        repeat (40) tick();
        keys[9] = 1'b0;
        repeat (20) tick();
        check_val("t2_count", 32'(popped.size() - base), 32'd1);
        check_val("t2_popped", 32'(popped[base]), 32'd9);
        check_val("t2_valid_low", 32'(key_valid), 32'd0);

        // 3: bounce on row 0 col 0; push only after a full stable window
        base = popped.size();
        wait_col(4'b0001);
        keys[0] = 1'b1; repeat (3) tick();
        keys[0] = 1'b0; repeat (2) tick();
        keys[0] = 1'b1; repeat (12) tick();
        check_val("t3_no_early_valid", 32'(key_valid), 32'd0);
        check_val("t3_no_early_pop", 32'(popped.size() - base), 32'd0);
        tick();
        check_val("t3_valid", 32'(key_valid), 32'd1);
        check_val("t3_code", 32'(key_code), 32'd0);
        repeat (30) tick();
        keys[0] = 1'b0;
        repeat (20) tick();
        check_val("t3_count", 32'(popped.size() - base), 32'd1);

        // 4: rows 0 and 2 on column 3; lowest row wins, row 2 after release
        base = popped.size();
        wait_col(4'b1000);
        keys[3]  = 1'b1;
        keys[11] = 1'b1;
        repeat (30) tick();
        check_val("t4_count", 32'(popped.size() - base), 32'd1);
        check_val("t4_code", 32'(popped[base]), 32'd3);
        keys[3] = 1'b0;
        n = 0;
        while (popped.size() < base + 2 && n < 80) begin tick(); n++; end
        check_val("t4_second_count", 32'(popped.size() - base), 32'd2);
        if (popped.size() >= base + 2) check_val("t4_second_code", 32'(popped[base+1]), 32'd11);
        keys[11] = 1'b0;
        repeat (20) tick();

        // 5: back-pressure, FIFO fill and overflow
        base = popped.size();
        key_ready = 1'b0;
        press_release(0);
        press_release(5);
        press_release(10);
        press_release(15);
        check_val("t5_full_no_ovf", 32'(overflow), 32'd0);
        check_val("t5_valid", 32'(key_valid), 32'd1);
        check_val("t5_head", 32'(key_code), 32'd0);
        press_release(1);
        check_val("t5_overflow", 32'(overflow), 32'd1);
        key_ready = 1'b1;
        repeat (8) tick();
        check_val("t5_pop_count", 32'(popped.size() - base), 32'd4);
        if (popped.size() >= base + 4) begin
            check_val("t5_pop0", 32'(popped[base]),   32'd0);
            check_val("t5_pop1", 32'(popped[base+1]), 32'd5);
            check_val("t5_pop2", 32'(popped[base+2]), 32'd10);
            check_val("t5_pop3", 32'(popped[base+3]), 32'd15);
        end
        check_val("t5_drained", 32'(key_valid), 32'd0);
        check_val("t5_code_hold", 32'(key_code), 32'd15);
        check_val("t5_ovf_sticky", 32'(overflow), 32'd1);

        // 6: reset during debounce, then hold code 6 (repeat when enabled)
        base = popped.size();
        wait_col(4'b0100);
        keys[6] = 1'b1;
        repeat (7) tick();
        rst = 1'b0;
        tick();
        check_val("t6_rst_columna", 32'(columna), 32'd1);
        check_val("t6_rst_valid", 32'(key_valid), 32'd0);
        check_val("t6_rst_overflow", 32'(overflow), 32'd0);
        check_val("t6_no_push", 32'(popped.size() - base), 32'd0);
        rst = 1'b1;
        n = 0;
        while (popped.size() == base && n < 64) begin tick(); n++; end
        check_val("t6_redetect", 32'(popped.size() - base), 32'd1);
        repeat (99) tick();
        keys[6] = 1'b0;
        repeat (20) tick();
        check_val("t6_hold_pushes", 32'(popped.size() - base), 32'(EXP_HOLD_PUSHES));
        if (popped.size() > base) check_val("t6_last_code", 32'(popped[popped.size()-1]), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
